bp_gshare_btb: RTL and testbench

BP_GSHARE_BTB -- requirements
Module: bp_gshare_btb

---
 rtl/bp_gshare_btb_if.sv | 26 ++
 rtl/bp_gshare_btb.sv | 71 +++++++
 tb/tb_bp_gshare_btb.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bp_gshare_btb_if.sv
// bp_gshare_btb_if: fetch lookup, EX resolve/update and statistics signals of the branch predictor.
interface bp_gshare_btb_if #(
    parameter int PC_BITS   = 12,
    parameter int STAT_BITS = 16
);
    logic [PC_BITS-1:0]   F_pc;
    logic                 MEM_stall;
    logic                 EX_brn;
    logic [PC_BITS-1:0]   EX_pc;
    logic [PC_BITS-1:0]   EX_alu_out;
    logic                 EX_true_taken;
    logic                 EX_BP_taken;
    logic                 F_BP_taken;
    logic [PC_BITS-1:0]   F_BP_target_pc;
    logic                 F_BP_hit;
    logic [STAT_BITS-1:0] BP_miss_cnt;

    modport master (
        output F_pc, MEM_stall, EX_brn, EX_pc, EX_alu_out, EX_true_taken, EX_BP_taken,
        input  F_BP_taken, F_BP_target_pc, F_BP_hit, BP_miss_cnt
    );
    modport slave (
        input  F_pc, MEM_stall, EX_brn, EX_pc, EX_alu_out, EX_true_taken, EX_BP_taken,
        output F_BP_taken, F_BP_target_pc, F_BP_hit, BP_miss_cnt
    );
endinterface

// File: rtl/bp_gshare_btb.sv
// bp_gshare_btb: direct-mapped BTB with per-entry saturating direction counters,
// indexed bimodally (PRED_MODE=0) or by PC XOR global history (PRED_MODE=1).
module bp_gshare_btb #(
    parameter int PC_BITS   = 12,
    parameter int ENTRIES   = 16,
    parameter int CNT_BITS  = 2,
    parameter int PRED_MODE = 0,
    parameter int STAT_BITS = 16
) (
    input logic            clk,
    input logic            rst,
    bp_gshare_btb_if.slave bp
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TAG = PC_BITS - IDX;
    localparam logic [CNT_BITS-1:0] WEAK_TAKEN = CNT_BITS'(1) << (CNT_BITS - 1);

    logic [ENTRIES-1:0]   valid;
    logic [TAG-1:0]       tag    [ENTRIES];
    logic [PC_BITS-1:0]   target [ENTRIES];
    logic [CNT_BITS-1:0]  ctr    [ENTRIES];
    logic [IDX-1:0]       ghr, hist, f_idx, u_idx;
    logic [TAG-1:0]       f_tag, u_tag;
    logic [CNT_BITS-1:0]  u_ctr, ctr_next;
    logic [STAT_BITS-1:0] miss_cnt;
    logic                 upd, u_hit, mispredict;

    // history still shifts in bimodal mode but is kept out of the index
    assign hist  = (PRED_MODE == 1) ? ghr : '0;
    assign f_idx = bp.F_pc[IDX-1:0] ^ hist;
    assign f_tag = bp.F_pc[PC_BITS-1:IDX];
    assign u_idx = bp.EX_pc[IDX-1:0] ^ hist;
    assign u_tag = bp.EX_pc[PC_BITS-1:IDX];

    assign bp.F_BP_hit       = valid[f_idx] && (tag[f_idx] == f_tag);
    assign bp.F_BP_taken     = bp.F_BP_hit && ctr[f_idx][CNT_BITS-1];
    assign bp.F_BP_target_pc = bp.F_BP_taken ? target[f_idx] : bp.F_pc + 1'b1;
    assign bp.BP_miss_cnt    = miss_cnt;

    assign upd        = bp.EX_brn && !bp.MEM_stall;
    assign u_hit      = valid[u_idx] && (tag[u_idx] == u_tag);
    assign u_ctr      = ctr[u_idx];
    assign mispredict = bp.EX_true_taken != bp.EX_BP_taken;
    assign ctr_next   = bp.EX_true_taken ? (&u_ctr ? u_ctr : u_ctr + 1'b1)
                                         : (|u_ctr ? u_ctr - 1'b1 : u_ctr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid    <= '0;
            ghr      <= '0;
            miss_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= '0;
        end else if (upd) begin
            ghr <= {ghr[IDX-2:0], bp.EX_true_taken};
            if (mispredict && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
            if (u_hit) ctr[u_idx] <= ctr_next;
            else if (bp.EX_true_taken) begin
                valid[u_idx] <= 1'b1;
                ctr[u_idx]   <= WEAK_TAKEN;
            end
        end
    end

    // a taken update either refreshes a hit entry or allocates over a miss; tag is unchanged on hit
    always_ff @(posedge clk) begin
        if (upd && rst && bp.EX_true_taken) begin
            tag[u_idx]    <= u_tag;
            target[u_idx] <= bp.EX_alu_out;
        end
    end
endmodule

// File: tb/tb_bp_gshare_btb.sv
// tb_bp_gshare_btb: directed and random checks of bimodal, gshare and narrow-statistics
// predictor instances against a table-level reference model.
module tb_bp_gshare_btb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] f_pc [3], ex_pc [3], ex_tg [3], tg_o [3];
    logic        brn [3], stall [3], tt [3], bpt [3], hit_o [3], tk_o [3];
    logic [15:0] mc_o [3];

    bp_gshare_btb_if #(.PC_BITS(12), .STAT_BITS(16)) i0 ();
    bp_gshare_btb_if #(.PC_BITS(12), .STAT_BITS(16)) i1 ();
    bp_gshare_btb_if #(.PC_BITS(12), .STAT_BITS(2))  i2 ();

    bp_gshare_btb #(.PRED_MODE(0))                d0 (.clk(clk), .rst(rst), .bp(i0));
    bp_gshare_btb #(.PRED_MODE(1))                d1 (.clk(clk), .rst(rst), .bp(i1));
    bp_gshare_btb #(.PRED_MODE(0), .STAT_BITS(2)) d2 (.clk(clk), .rst(rst), .bp(i2));

    assign i0.F_pc = f_pc[0];  assign i0.MEM_stall = stall[0];  assign i0.EX_brn = brn[0];
    assign i0.EX_pc = ex_pc[0];  assign i0.EX_alu_out = ex_tg[0];
    assign i0.EX_true_taken = tt[0];  assign i0.EX_BP_taken = bpt[0];
    assign i1.F_pc = f_pc[1];  assign i1.MEM_stall = stall[1];  assign i1.EX_brn = brn[1];
    assign i1.EX_pc = ex_pc[1];  assign i1.EX_alu_out = ex_tg[1];
    assign i1.EX_true_taken = tt[1];  assign i1.EX_BP_taken = bpt[1];
    assign i2.F_pc = f_pc[2];  assign i2.MEM_stall = stall[2];  assign i2.EX_brn = brn[2];
    assign i2.EX_pc = ex_pc[2];  assign i2.EX_alu_out = ex_tg[2];
    assign i2.EX_true_taken = tt[2];  assign i2.EX_BP_taken = bpt[2];
    assign hit_o[0] = i0.F_BP_hit;  assign tk_o[0] = i0.F_BP_taken;
    assign tg_o[0] = i0.F_BP_target_pc;  assign mc_o[0] = i0.BP_miss_cnt;
    assign hit_o[1] = i1.F_BP_hit;  assign tk_o[1] = i1.F_BP_taken;
    assign tg_o[1] = i1.F_BP_target_pc;  assign mc_o[1] = i1.BP_miss_cnt;
    assign hit_o[2] = i2.F_BP_hit;  assign tk_o[2] = i2.F_BP_taken;
    assign tg_o[2] = i2.F_BP_target_pc;  assign mc_o[2] = {14'b0, i2.BP_miss_cnt};

    // reference model: one row of table state per instance; instance 1 is gshare
    int mv [3][16], mt [3][16], mg [3][16], mc [3][16];
    int mghr [3], mmiss [3];
    int mmax [3] = '{65535, 65535, 3};
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 3; k++) begin
            mghr[k] = 0;
            mmiss[k] = 0;
            for (int e = 0; e < 16; e++) begin
                mv[k][e] = 0; mt[k][e] = 0; mg[k][e] = 0; mc[k][e] = 0;
            end
        end
    endtask

    function automatic int midx(input int k, input int pc);
        return (pc % 16) ^ ((k == 1) ? mghr[k] : 0);
    endfunction

    task automatic mpred(input int k, input int pc, output int h, output int t, output int tg);
        int e;
        e  = midx(k, pc);
        h  = (mv[k][e] != 0 && mt[k][e] == pc / 16) ? 1 : 0;
        t  = (h != 0 && mc[k][e] >= 2) ? 1 : 0;
        tg = (t != 0) ? mg[k][e] : (pc + 1) % 4096;
    endtask

    task automatic mupd(input int k, input int pc, input int tg, input bit t, input bit bp);
        int e;
        e = midx(k, pc);
        if (mv[k][e] != 0 && mt[k][e] == pc / 16) begin
            mc[k][e] = t ? ((mc[k][e] < 3) ? mc[k][e] + 1 : 3) : ((mc[k][e] > 0) ? mc[k][e] - 1 : 0);
            if (t) mg[k][e] = tg;
        end else if (t) begin
            mv[k][e] = 1; mt[k][e] = pc / 16; mg[k][e] = tg; mc[k][e] = 2;
        end
        mghr[k] = (mghr[k] * 2 + int'(t)) % 16;
        if (t != bp && mmiss[k] < mmax[k]) mmiss[k]++;
    endtask

    task automatic look_chk(input int k);
        int h, t, tg;
        mpred(k, int'(f_pc[k]), h, t, tg);
        chk($sformatf("hit[%0d] pc=%0h", k, f_pc[k]), hit_o[k], h);
        chk($sformatf("taken[%0d] pc=%0h", k, f_pc[k]), tk_o[k], t);
        chk($sformatf("target[%0d] pc=%0h", k, f_pc[k]), tg_o[k], tg);
        chk($sformatf("miss_cnt[%0d]", k), mc_o[k], mmiss[k]);
    endtask

    task automatic lookup(input int k, input int pc);
        @(negedge clk);
        f_pc[k] = 12'(pc);
        #1 look_chk(k);
    endtask

    // lookup is checked before the edge, so fpc==pc exercises the no-bypass rule
    task automatic upd(input int k, input int pc, input int tg, input bit t, input bit bp,
                       input bit st, input int fpc);
        @(negedge clk);
        f_pc[k] = 12'(fpc); ex_pc[k] = 12'(pc); ex_tg[k] = 12'(tg);
        tt[k] = t; bpt[k] = bp; stall[k] = st; brn[k] = 1'b1;
        #1 look_chk(k);
        @(posedge clk);
        if (!st) mupd(k, pc, tg, t, bp);
        #1;
        brn[k] = 1'b0;
        stall[k] = 1'b0;
    endtask

    task automatic expect_lu(input int k, input int pc, input bit h, input bit t, input int tg);
        @(negedge clk);
        f_pc[k] = 12'(pc);
        #1;
        chk($sformatf("dir_hit[%0d] pc=%0h", k, pc), hit_o[k], h);
        chk($sformatf("dir_taken[%0d] pc=%0h", k, pc), tk_o[k], t);
        chk($sformatf("dir_target[%0d] pc=%0h", k, pc), tg_o[k], tg);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            f_pc[k] = '0; ex_pc[k] = '0; ex_tg[k] = '0;
            brn[k] = 0; stall[k] = 0; tt[k] = 0; bpt[k] = 0;
        end
        mreset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        expect_lu(0, 'h010, 0, 0, 'h011);
        expect_lu(0, 'hFFF, 0, 0, 'h000);
        upd(0, 'h010, 'h200, 1, 0, 0, 'h010);
        expect_lu(0, 'h010, 1, 1, 'h200);
        chk("miss_after_alloc", mc_o[0], 1);
        upd(0, 'h010, 'h200, 0, 1, 0, 'h010);
        expect_lu(0, 'h010, 1, 0, 'h011);
        upd(0, 'h010, 'h200, 0, 1, 0, 'h010);
        expect_lu(0, 'h010, 1, 0, 'h011);
        repeat (4) upd(0, 'h010, 'h200, 1, 1, 0, 'h010);
        upd(0, 'h010, 'h200, 0, 1, 0, 'h010);
        expect_lu(0, 'h010, 1, 1, 'h200);
        upd(0, 'h020, 'h300, 1, 0, 0, 'h010);
        expect_lu(0, 'h010, 0, 0, 'h011);
        expect_lu(0, 'h020, 1, 1, 'h300);
        upd(0, 'h030, 'h400, 0, 0, 0, 'h020);
        expect_lu(0, 'h020, 1, 1, 'h300);
        expect_lu(0, 'h030, 0, 0, 'h031);
        repeat (3) upd(0, 'h020, 'h777, 1, 0, 1, 'h020);
        expect_lu(0, 'h020, 1, 1, 'h300);
        chk("miss_after_stall", mc_o[0], 5);
        lookup(0, 'h020);
        upd(1, 'h100, 'h111, 1, 0, 0, 'h000);
        upd(1, 'h200, 'h222, 1, 0, 0, 'h000);
        upd(1, 'h004, 'h123, 1, 0, 0, 'h004);
        expect_lu(1, 'h000, 1, 1, 'h123);
        expect_lu(1, 'h004, 0, 0, 'h005);
        @(negedge clk);
        f_pc[1] = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_hit", hit_o[1], 0);
        chk("rst_taken", tk_o[1], 0);
        chk("rst_target", tg_o[1], 'h001);
        chk("rst_miss", mc_o[1], 0);
        mreset();
        ex_pc[0] = 'h050; ex_tg[0] = 'h555; tt[0] = 1; bpt[0] = 0; brn[0] = 1;
        @(posedge clk);
        #1 brn[0] = 0;
        @(negedge clk);
        rst = 1'b1;
        expect_lu(0, 'h050, 0, 0, 'h051);
        chk("abort_miss", mc_o[0], 0);
        repeat (5) upd(2, 'h008, 'h088, 1, 0, 0, 'h008);
        chk("miss_saturate", mc_o[2], 3);
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 200; n++) begin
                int pc, fpc;
                pc  = ($urandom % 8 == 0) ? int'($urandom % 4096) : int'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
                fpc = ($urandom % 3 == 0) ? pc : int'($urandom % 64);
                upd(k, pc, int'($urandom % 4096), 1'($urandom % 2), 1'($urandom % 2), ($urandom % 5) == 0, fpc);
            end
            lookup(k, int'($urandom % 64));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
